// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry held in a flop.
// Ports: clk, rst(async high), start, a, b, c_in -> busy, done, s, c_out.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_sum_bit;
    logic             w_carry_next;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_sum_next;

    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) |
                          (r_b[0] & r_carry) |
                          (r_a[0] & r_carry);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB so the first bit ends up at bit 0.
    assign w_sum_next   = (r_sum >> 1) |
                          (WIDTH'(w_sum_bit) << (WIDTH - 1));

    // Start is only honoured when no addition is in flight.
    assign w_load       = start &&
                          ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            c_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= c_in;
                r_cnt   <= '0;
                busy    <= 1'b1;
                r_state <= RUN;
            end else begin
                unique case (r_state)
                    RUN: begin
                        r_sum   <= w_sum_next;
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_carry <= w_carry_next;
                        if (w_last) begin
                            s       <= w_sum_next;
                            c_out   <= w_carry_next;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Scoreboard queues hold expected {c_out,s} and start cycle per op.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       st8 = 1'b0;
    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;
    logic       c8  = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       co8;

    logic       st1 = 1'b0;
    logic [0:0] a1  = '0;
    logic [0:0] b1  = '0;
    logic       c1  = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] s1;
    logic       co1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (st8),
        .a     (a8),
        .b     (b8),
        .c_in  (c8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .c_out (co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (st1),
        .a     (a1),
        .b     (b1),
        .c_in  (c1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .c_out (co1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] v;
        int         t;
    } e8_t;

    typedef struct {
        logic [1:0] v;
        int         t;
    } e1_t;

    e8_t q8[$];
    e1_t q1[$];
    int  last_done8 = -1;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((busy8 & done8) !== 1'b0) begin
                errors++;
                $display("FAIL busy_done8 got %b want 0", busy8 & done8);
            end
            if (done8 === 1'b1) begin
                last_done8 = cyc;
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done8 got 1 want 0");
                end else begin
                    e8_t e;
                    e = q8.pop_front();
                    if ({co8, s8} !== e.v) begin
                        errors++;
                        $display("FAIL sum8 got %h want %h", {co8, s8}, e.v);
                    end
                    checks++;
                    if (cyc - e.t != 8) begin
                        errors++;
                        $display("FAIL latency8 got %0d want 8", cyc - e.t);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((busy1 & done1) !== 1'b0) begin
                errors++;
                $display("FAIL busy_done1 got %b want 0", busy1 & done1);
            end
            if (done1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done1 got 1 want 0");
                end else begin
                    e1_t e;
                    e = q1.pop_front();
                    if ({co1, s1} !== e.v) begin
                        errors++;
                        $display("FAIL sum1 got %h want %h", {co1, s1}, e.v);
                    end
                    checks++;
                    if (cyc - e.t != 1) begin
                        errors++;
                        $display("FAIL latency1 got %0d want 1", cyc - e.t);
                    end
                end
            end
        end
    end

    task automatic start8(input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input bit push);
        @(negedge clk);
        a8  = ia;
        b8  = ib;
        c8  = ic;
        st8 = 1'b1;
        if (push) q8.push_back('{9'(ia) + 9'(ib) + 9'(ic), cyc + 1});
        @(negedge clk);
        st8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        c8  = 1'($urandom);
    endtask

    task automatic wait8();
        int n = 0;
        while (q8.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL timeout8 got %0d pending want 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic);
        start8(ia, ib, ic, 1'b1);
        wait8();
    endtask

    task automatic run_op1(input logic ia, input logic ib, input logic ic);
        int n = 0;
        @(negedge clk);
        a1  = ia;
        b1  = ib;
        c1  = ic;
        st1 = 1'b1;
        q1.push_back('{2'(ia) + 2'(ib) + 2'(ic), cyc + 1});
        @(negedge clk);
        st1 = 1'b0;
        a1  = 1'($urandom);
        b1  = 1'($urandom);
        c1  = 1'($urandom);
        while (q1.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL timeout1 got %0d pending want 0", q1.size());
            q1.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op8(8'h01, 8'h02, 1'b0);
        run_op1(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, co8, s8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 got %h want 0", {busy8, done8, co8, s8});
        end
        checks++;
        if ({busy1, done1, co1, s1} !== 4'd0) begin
            errors++;
            $display("FAIL reset1 got %h want 0", {busy1, done1, co1, s1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_carry_out();
        start8(8'hFF, 8'h01, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL run_flags got busy=%b done=%b want 1 0",
                         busy8, done8);
            end
            @(negedge clk);
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL done_flags got busy=%b done=%b want 0 1",
                     busy8, done8);
        end
        wait8();
    endtask

    task automatic test_carry_chain();
        run_op8(8'hA5, 8'h5A, 1'b1);
        run_op8(8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_done;
        @(negedge clk);
        a8  = 8'h3C;
        b8  = 8'h0F;
        c8  = 1'b0;
        st8 = 1'b1;
        q8.push_back('{9'h04B, cyc + 1});
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            a8 = ~a8;
            b8 = ~b8;
        end
        @(negedge clk);
        first_done = cyc;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done got %b want 1", done8);
        end
        a8 = 8'h12;
        b8 = 8'h34;
        c8 = 1'b1;
        q8.push_back('{9'h047, cyc + 1});
        @(negedge clk);
        st8 = 1'b0;
        a8  = 8'hEE;
        b8  = 8'hDD;
        wait8();
        checks++;
        if (last_done8 - first_done != 9) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 9",
                     last_done8 - first_done);
        end
    endtask

    task automatic test_reset_mid();
        start8(8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, co8, s8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", {busy8, done8, co8, s8});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if ({busy8, co8, s8} !== 10'd0) begin
            errors++;
            $display("FAIL after_abort got %h want 0", {busy8, co8, s8});
        end
        run_op8(8'h01, 8'h02, 1'b0);
    endtask

    task automatic test_random8();
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_random1();
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op1(1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_carry_out();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random1();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
